hazard_ctrl: RTL
================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter N, default 16, sets the width of the stall and flush event counters.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 valid_D  input  1  a real instruction occupies IF/ID.
REQ-005 ra1_D, ra2_D  input  5 each  source register numbers of the ID-stage instruction.
REQ-006 useRa1_D, useRa2_D  input  1 each  the ID instruction actually reads ra1_D / ra2_D.
REQ-007 rd_D  input  5  destination register of the ID instruction.
REQ-008 regWrite_D, memRead_D  input  1 each  the ID instruction writes rd_D / is a load.
REQ-009 branchTaken_M  input  1  the instruction in MEM is a taken branch.
REQ-010 stall_F, stall_D  output  1 each  hold PC and IF/ID this cycle.
REQ-011 bubble_E  output  1  load NOP into ID/EX at the next edge.
REQ-012 flush  output  1  squash IF/ID, ID/EX and EX/MEM at the next edge.
REQ-013 forwardA_E, forwardB_E  output  2 each  registered ALU-operand selects for the EX instruction: 00 register file, 10 EX/MEM, 01 MEM/WB.
REQ-014 state_o  output  2  previous-cycle action: 00 RUN, 01 STALL, 10 FLUSH.
REQ-015 stallCount, flushCount  output  N each  saturating event counters.

Function
REQ-016 Block SHALL keep a scoreboard of three entries (EX, MEM, WB), each holding {valid, rd, regWrite, memRead} for the instruction occupying that stage.
REQ-017 Load-use hazard (loadUse) SHALL be true when: EX.valid and EX.memRead and EX.rd != 31 and valid_D and ((useRa1_D and ra1_D == EX.rd) or (useRa2_D and ra2_D == EX.rd)).
REQ-018 flush SHALL equal branchTaken_M, combinationally.
REQ-019 stall_F = stall_D = bubble_E SHALL equal loadUse and not branchTaken_M; flush has priority over stall.
REQ-020 At each edge: WB <= MEM; MEM <= EX, or invalid if flush; EX <= {valid_D, rd_D, regWrite_D, memRead_D}, or invalid if flush or stall.
REQ-021 Next forwardA_E SHALL be 10 if EX.valid, EX.regWrite, EX.rd != 31 and EX.rd == ra1_D; else 01 if the same holds for the MEM entry; else 00. EX takes priority over MEM.
REQ-022 forwardB_E SHALL follow the same rule using ra2_D.
REQ-023 forwardA_E and forwardB_E SHALL register at the same edge the ID instruction enters EX, so they are valid during its EX cycle.
REQ-024 Both forward selects SHALL register as 00 when stall or flush is asserted or valid_D = 0.
REQ-025 Register 31 (XZR) SHALL never cause a forward or a stall.
REQ-026 A hazard with the WB-stage instruction is resolved by register-file write-through, not by this block.
REQ-027 state_o SHALL register FLUSH if flush, else STALL if stall, else RUN.
REQ-028 stallCount SHALL increment by one on each edge with stall asserted and saturate at 2^N-1; flushCount SHALL do the same for flush.
REQ-029 A load-use stall SHALL last exactly one cycle: after the bubble the load sits in MEM and the consumer forwards 01.
REQ-030 All outputs other than stall_F, stall_D, bubble_E and flush SHALL be registered.

Reset
REQ-031 While reset = 0, all scoreboard entries SHALL be invalid, forwardA_E = forwardB_E = 00, state_o = RUN and both counters = 0, asynchronously.
REQ-032 Combinational outputs SHALL be 0 during reset, because the scoreboard is empty and branchTaken_M is ignored.
REQ-033 A reset asserted mid-stall or mid-flush SHALL discard all in-flight scoreboard entries with no residual stall.

Verification
REQ-034 ADD X1 followed by SUB X2,X1,X3 -> during SUB's EX cycle forwardA_E = 10, no stall.
REQ-035 ADD X1, NOP, then ORR reading X1 as ra2 -> forwardB_E = 01; ADD X1 then ADD X1 then a reader of X1 -> forwardA_E = 10 (EX wins).
REQ-036 LDUR X4 followed immediately by ADD X5,X4,X4 -> one cycle with stall_F = stall_D = bubble_E = 1; stallCount = 1; ADD then gets forwardA_E = forwardB_E = 01; state_o = STALL for one cycle.
REQ-037 branchTaken_M = 1 in the same cycle as a load-use condition -> flush = 1, stall = 0; EX and MEM entries invalidated; flushCount = 1; state_o = FLUSH.
REQ-038 Writer with rd = 31 followed by a reader of X31 -> forward selects stay 00 and no stall; a load to X31 followed by its consumer -> no stall.
REQ-039 Force stallCount to 2^N-1 with N = 4, run 20 consecutive stalls -> count holds at 15; then assert reset low mid-stall -> all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use stall, branch flush and EX/MEM forwarding control with event counters
module hazard_ctrl #(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         valid_D,
  input  logic [4:0]   ra1_D,
  input  logic [4:0]   ra2_D,
  input  logic         useRa1_D,
  input  logic         useRa2_D,
  input  logic [4:0]   rd_D,
  input  logic         regWrite_D,
  input  logic         memRead_D,
  input  logic         branchTaken_M,
  output logic         stall_F,
  output logic         stall_D,
  output logic         bubble_E,
  output logic         flush,
  output logic [1:0]   forwardA_E,
  output logic [1:0]   forwardB_E,
  output logic [1:0]   state_o,
  output logic [N-1:0] stallCount,
  output logic [N-1:0] flushCount
);
  typedef struct packed {
    logic       v;
    logic [4:0] rd;
    logic       rw;
    logic       mr;
  } entry_t;
  typedef enum logic [1:0] {RUN = 2'b00, STALL = 2'b01, FLUSH = 2'b10} state_t;
  entry_t sb [3];
  state_t state;
  logic   load_use;
  logic   stall;
  function automatic logic hit(entry_t e, logic [4:0] r);
    return e.v && e.rw && e.rd != 5'd31 && e.rd == r;
  endfunction
  function automatic logic [1:0] fwd(entry_t ex, entry_t mem, logic [4:0] r);
    return hit(ex, r) ? 2'b10 : hit(mem, r) ? 2'b01 : 2'b00;
  endfunction
  always_comb begin
    load_use = sb[0].v && sb[0].mr && sb[0].rd != 5'd31 && valid_D &&
               ((useRa1_D && ra1_D == sb[0].rd) || (useRa2_D && ra2_D == sb[0].rd));
    flush    = branchTaken_M && reset;
    stall    = load_use && !flush;
  end
  assign stall_F  = stall;
  assign stall_D  = stall;
  assign bubble_E = stall;
  assign state_o  = state;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 3; i++) sb[i] <= '0;
      forwardA_E <= 2'b00;
      forwardB_E <= 2'b00;
      state      <= RUN;
      stallCount <= '0;
      flushCount <= '0;
    end else begin
      sb[2]      <= sb[1];
      sb[1]      <= flush ? '0 : sb[0];
      sb[0]      <= (flush || stall) ? '0 : {valid_D, rd_D, regWrite_D, memRead_D};
      forwardA_E <= (flush || stall || !valid_D) ? 2'b00 : fwd(sb[0], sb[1], ra1_D);
      forwardB_E <= (flush || stall || !valid_D) ? 2'b00 : fwd(sb[0], sb[1], ra2_D);
      state      <= flush ? FLUSH : stall ? STALL : RUN;
      if (stall && stallCount != '1) stallCount <= stallCount + N'(1);
      if (flush && flushCount != '1) flushCount <= flushCount + N'(1);
    end
  end
endmodule
